uart_dbg_bridge: RTL and testbench

- Host-side debug/boot bridge: receives command frames on a UART RX pin and acts as a second initiator on the system bus (memory, GEMM config, UART regions). Replies go out on UART TX.
- Mirrors the core's role: the core talks to a UART responder; this block lets an external host drive the bus through a UART.
- Sits beside the RISC-V core behind an external 2-master arbiter (req/gnt).

---
 rtl/uart_dbg_bridge_pkg.sv | 20 ++
 rtl/uart_dbg_phy.sv | 129 ++++++++++++
 rtl/uart_dbg_bridge.sv | 165 ++++++++++++++++
 tb/tb_uart_dbg_bridge.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_dbg_bridge_pkg.sv
// Shared constants for the UART debug bridge: command/reply bytes and the
// frame FSM state encoding.
package uart_dbg_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W' + addr[4] + data[4]
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R' + addr[4]
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    StIdle,
    StRxAddr,
    StRxData,
    StBusReq,
    StBusAcc,
    StRdWait,
    StTxReply
  } state_e;

endpackage

// File: rtl/uart_dbg_phy.sv
// UART 8N1 physical layer for the debug bridge.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rxd                 serial in (asynchronous, idle high)
//   txd                 serial out (idle high)
//   rx_valid, rx_data   one-cycle pulse with a correctly framed received byte
//   tx_valid, tx_ready  byte handshake; a byte is taken when both are high
//   tx_data             byte to transmit
module uart_dbg_phy #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       txd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e     rx_state_q;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid   <= 1'b0;
    end else begin
      rx_meta_q <= rxd;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      rx_valid  <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RxStart;
            rx_cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (rx_cnt_q == HALF) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            // A start bit that is high again at mid-bit was a glitch.
            rx_state_q <= rx_sync_q ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (rx_cnt_q == FULL) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
            else                  rx_bit_q   <= rx_bit_q + 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: begin  // RxStop: a low stop bit silently drops the byte
          if (rx_cnt_q == FULL) begin
            rx_valid   <= rx_sync_q;
            rx_state_q <= RxIdle;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign rx_data = rx_shift_q;

  logic          tx_busy_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic [9:0]    tx_shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      txd        <= 1'b1;
    end else if (!tx_busy_q) begin
      txd <= 1'b1;
      if (tx_valid) begin
        tx_busy_q  <= 1'b1;
        tx_shift_q <= {1'b1, tx_data, 1'b0};
        tx_cnt_q   <= '0;
        tx_bit_q   <= '0;
        txd        <= 1'b0;
      end
    end else if (tx_cnt_q == FULL) begin
      tx_cnt_q <= '0;
      if (tx_bit_q == 4'd9) begin
        tx_busy_q <= 1'b0;
        txd       <= 1'b1;
      end else begin
        tx_bit_q   <= tx_bit_q + 1'b1;
        tx_shift_q <= {1'b1, tx_shift_q[9:1]};
        txd        <= tx_shift_q[1];
      end
    end else begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
    end
  end

  assign tx_ready = !tx_busy_q;

endmodule

// File: rtl/uart_dbg_bridge.sv
// Host debug/boot bridge: decodes 'W'/'R' command frames from a UART and
// performs single word accesses on the system bus as a second initiator.
// Optional macro UART_DBG_BRIDGE_TIMEOUT_EN: abandon a partial frame after
// TIMEOUT_CYCLES without a new byte.
// Ports:
//   clk, rst_n                system clock, asynchronous active-low reset
//   uart_rxd_i, uart_txd_o    host UART
//   bus_req_o, bus_gnt_i      arbiter handshake
//   system_bus_*              single-cycle strobe bus, word addressed
//   busy_o                    high whenever the frame FSM is not idle
module uart_dbg_bridge
  import uart_dbg_bridge_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rxd_i,
  output logic        uart_txd_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic        system_bus_en,
  output logic        system_bus_rdwr,
  output logic [3:0]  system_bus_mask,
  output logic [31:0] system_bus_addr,
  output logic [31:0] system_bus_wr_data,
  input  logic [31:0] system_bus_rd_data,
  output logic        busy_o
);

  logic       rx_valid, tx_valid, tx_ready;
  logic [7:0] rx_data, tx_data;

  uart_dbg_phy #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_phy (
    .clk     (clk),
    .rst_n   (rst_n),
    .rxd     (uart_rxd_i),
    .txd     (uart_txd_o),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data (tx_data)
  );

  state_e      state_q;
  logic [1:0]  cnt_q, last_q, lat_q;
  logic        is_wr_q, timeout;
  logic [31:0] addr_q, wdata_q, rsp_q;

`ifdef UART_DBG_BRIDGE_TIMEOUT_EN
  logic [31:0] idle_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else if (rx_valid || !(state_q == StRxAddr || state_q == StRxData)) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end

  assign timeout = (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= '0;
      lat_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_valid) begin
            cnt_q <= '0;
            if (rx_data == CMD_WR || rx_data == CMD_RD) begin
              is_wr_q <= (rx_data == CMD_WR);
              state_q <= StRxAddr;
            end else begin
              rsp_q   <= {24'h0, RSP_NAK};
              last_q  <= 2'd0;
              state_q <= StTxReply;
            end
          end
        end
        StRxAddr: begin
          if (rx_valid) begin
            // Little-endian: each new byte enters at the top and shifts down.
            addr_q <= {rx_data, addr_q[31:8]};
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == 2'd3) state_q <= is_wr_q ? StRxData : StBusReq;
          end else if (timeout) begin
            state_q <= StIdle;
          end
        end
        StRxData: begin
          if (rx_valid) begin
            wdata_q <= {rx_data, wdata_q[31:8]};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == 2'd3) state_q <= StBusReq;
          end else if (timeout) begin
            state_q <= StIdle;
          end
        end
        StBusReq: begin
          if (bus_gnt_i) state_q <= StBusAcc;
        end
        StBusAcc: begin
          lat_q <= '0;
          if (is_wr_q) begin
            rsp_q   <= {24'h0, RSP_ACK};
            last_q  <= 2'd0;
            state_q <= StTxReply;
          end else begin
            state_q <= StRdWait;
          end
        end
        StRdWait: begin
          if (lat_q == 2'(RD_LATENCY - 1)) begin
            rsp_q   <= system_bus_rd_data;
            last_q  <= 2'd3;
            state_q <= StTxReply;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        default: begin  // StTxReply; cnt_q is 0 on entry from every path
          if (tx_ready) begin
            rsp_q <= {8'h0, rsp_q[31:8]};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == last_q) begin
              cnt_q   <= '0;
              state_q <= StIdle;
            end
          end
        end
      endcase
    end
  end

  assign tx_valid = (state_q == StTxReply);
  assign tx_data  = rsp_q[7:0];

  assign bus_req_o          = (state_q == StBusReq) || (state_q == StBusAcc) ||
                              (state_q == StRdWait);
  assign system_bus_en      = (state_q == StBusAcc);
  assign system_bus_rdwr    = bus_req_o & is_wr_q;
  assign system_bus_mask    = {4{bus_req_o}};
  assign system_bus_addr    = {addr_q[31:2], 2'b00};
  assign system_bus_wr_data = wdata_q;
  assign busy_o             = (state_q != StIdle);

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Directed scoreboard bench for uart_dbg_bridge: stimulus pushes expected bus
// accesses and reply bytes; bus and UART TX monitors pop and compare them.
module tb_uart_dbg_bridge;

  localparam int unsigned CPB    = 16;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned TO_CYC = 5000;

  typedef struct {
    logic        rdwr;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_rxd;
  logic        uart_txd_o;
  logic        bus_req_o;
  logic        bus_gnt;
  logic        system_bus_en;
  logic        system_bus_rdwr;
  logic [3:0]  system_bus_mask;
  logic [31:0] system_bus_addr;
  logic [31:0] system_bus_wr_data;
  logic [31:0] system_bus_rd_data;
  logic        busy_o;

  int          checks = 0;
  int          failures = 0;
  bus_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  frame[$];
  logic [31:0] rd_val;
  int          pend;
  int          drop_cnt;
  logic        tx_abort;

  always #5 clk = ~clk;

  uart_dbg_bridge #(
    .CLKS_PER_BIT  (CPB),
    .RD_LATENCY    (RD_LAT),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .uart_rxd_i        (uart_rxd),
    .uart_txd_o        (uart_txd_o),
    .bus_req_o         (bus_req_o),
    .bus_gnt_i         (bus_gnt),
    .system_bus_en     (system_bus_en),
    .system_bus_rdwr   (system_bus_rdwr),
    .system_bus_mask   (system_bus_mask),
    .system_bus_addr   (system_bus_addr),
    .system_bus_wr_data(system_bus_wr_data),
    .system_bus_rd_data(system_bus_rd_data),
    .busy_o            (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read responder: data is valid only in the cycle RD_LAT after the strobe.
  always @(negedge clk) begin
    system_bus_rd_data <= 32'hBAD0_BAD0;
    if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) system_bus_rd_data <= rd_val;
    end
    if (rst_n && system_bus_en && !system_bus_rdwr) pend <= RD_LAT;
  end

  // Bus monitor: compares each strobe with the scoreboard and checks when
  // bus_req_o is released afterwards.
  always @(negedge clk) begin
    bus_t t;
    if (!rst_n) begin
      drop_cnt <= 0;
    end else begin
      if (drop_cnt != 0) begin
        drop_cnt <= drop_cnt - 1;
        if (drop_cnt == 1) check("req_drop", {31'b0, bus_req_o}, 32'd0);
        else               check("req_hold", {31'b0, bus_req_o}, 32'd1);
      end
      if (system_bus_en) begin
        if (exp_bus.size() == 0) begin
          check("bus_unexpected", exp_bus.size(), 32'd1);
        end else begin
          t = exp_bus.pop_front();
          check("bus_rdwr", {31'b0, system_bus_rdwr}, {31'b0, t.rdwr});
          check("bus_addr", system_bus_addr, t.addr);
          check("bus_mask", {28'b0, system_bus_mask}, 32'hF);
          check("bus_en_req", {31'b0, bus_req_o}, 32'd1);
          if (t.rdwr) check("bus_wr_data", system_bus_wr_data, t.data);
        end
        drop_cnt <= system_bus_rdwr ? 1 : RD_LAT + 1;
      end
    end
  end

  // UART TX monitor: samples each bit near its centre.
  initial begin
    logic [7:0] b;
    logic       stop;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_txd_o === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_txd_o;
        end
        repeat (CPB) @(negedge clk);
        stop = uart_txd_o;
        if (tx_abort) begin
          tx_abort = 1'b0;
        end else if (exp_tx.size() == 0) begin
          check("tx_unexpected", exp_tx.size(), 32'd1);
        end else begin
          e = exp_tx.pop_front();
          check("tx_byte", {24'b0, b}, {24'b0, e});
          check("tx_stop", {31'b0, stop}, 32'd1);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i], 1'b1);
  endtask

  task automatic push_bus(input logic rdwr, input logic [31:0] addr, input logic [31:0] data);
    bus_t t;
    t.rdwr = rdwr;
    t.addr = addr;
    t.data = data;
    exp_bus.push_back(t);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0 || busy_o) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, n < 20000}, 32'd1);
    repeat (2 * CPB) @(negedge clk);
    check("idle_busy", {31'b0, busy_o}, 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_txd", {31'b0, uart_txd_o}, 32'd1);
    check("rst_req", {31'b0, bus_req_o}, 32'd0);
    check("rst_en", {31'b0, system_bus_en}, 32'd0);
    check("rst_rdwr", {31'b0, system_bus_rdwr}, 32'd0);
    check("rst_mask", {28'b0, system_bus_mask}, 32'd0);
    check("rst_addr", system_bus_addr, 32'd0);
    check("rst_wdata", system_bus_wr_data, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    int n;
    logic ok;
    rst_n    = 1'b0;
    uart_rxd = 1'b1;
    bus_gnt  = 1'b1;
    rd_val   = 32'h0;
    pend     = 0;
    drop_cnt = 0;
    tx_abort = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write with grant tied high.
    push_bus(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    exp_tx.push_back(8'h06);
    frame = '{8'h57, 8'h00, 8'h01, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame();
    wait_idle("write_done");

    // Read; address low bits from the host are dropped.
    rd_val = 32'h1234_5678;
    push_bus(1'b0, 32'h0000_0100, 32'h0);
    exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
    frame = '{8'h52, 8'h03, 8'h01, 8'h00, 8'h00};
    send_frame();
    wait_idle("read_done");

    // Write with grant held low for 50 cycles.
    bus_gnt = 1'b0;
    push_bus(1'b1, 32'h0000_0200, 32'hCAFE_F00D);
    exp_tx.push_back(8'h06);
    frame = '{8'h57, 8'h02, 8'h02, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    send_frame();
    n = 0;
    while (!bus_req_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("gnt_req_rise", {31'b0, bus_req_o}, 32'd1);
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!bus_req_o || system_bus_en) ok = 1'b0;
    end
    check("gnt_req_held", {31'b0, ok}, 32'd1);
    check("gnt_no_early_en", exp_bus.size(), 32'd1);
    bus_gnt = 1'b1;
    wait_idle("gnt_done");

    // Unknown command gets a NAK.
    exp_tx.push_back(8'h15);
    send_byte(8'h41, 1'b1);
    wait_idle("nak_done");

    // Framing error: command byte with a low stop bit is discarded.
    send_byte(8'h52, 1'b0);
    repeat (4 * CPB) @(negedge clk);
    check("frame_err_busy", {31'b0, busy_o}, 32'd0);
    check("frame_err_tx", exp_tx.size(), 32'd0);

`ifdef UART_DBG_BRIDGE_TIMEOUT_EN
    // Partial frame is abandoned after the idle timeout.
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (TO_CYC - 100) @(negedge clk);
    check("to_still_busy", {31'b0, busy_o}, 32'd1);
    repeat (200) @(negedge clk);
    check("to_idle", {31'b0, busy_o}, 32'd0);
    rd_val = 32'h0BAD_F00D;
    push_bus(1'b0, 32'h0000_0080, 32'h0);
    exp_tx.push_back(8'h0D); exp_tx.push_back(8'hF0);
    exp_tx.push_back(8'hAD); exp_tx.push_back(8'h0B);
    frame = '{8'h52, 8'h80, 8'h00, 8'h00, 8'h00};
    send_frame();
    wait_idle("to_read_done");
`endif

    // Reset while the third reply byte of a read is on the wire.
    rd_val = 32'hA1B2_C3D4;
    push_bus(1'b0, 32'h0000_0040, 32'h0);
    exp_tx.push_back(8'hD4); exp_tx.push_back(8'hC3);
    exp_tx.push_back(8'hB2); exp_tx.push_back(8'hA1);
    frame = '{8'h52, 8'h40, 8'h00, 8'h00, 8'h00};
    send_frame();
    n = 0;
    while (exp_tx.size() > 2 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_byte2", exp_tx.size(), 32'd2);
    repeat (3 * CPB) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy_o}, 32'd1);
    tx_abort = 1'b1;
    exp_tx.delete();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Fresh write after reset.
    push_bus(1'b1, 32'h0000_0010, 32'h5555_AAAA);
    exp_tx.push_back(8'h06);
    frame = '{8'h57, 8'h12, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hAA, 8'h55, 8'h55};
    send_frame();
    wait_idle("post_rst_done");

    check("tx_leftover", exp_tx.size(), 32'd0);
    check("bus_leftover", exp_bus.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
